// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding and PC step.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_RST_HOLD = 2'd0,
      ST_FETCH    = 2'd1,
      ST_EXEC     = 2'd2,
      ST_HALTED   = 2'd3
   } state_t;

   localparam int PC_INCR = 4;

endpackage

// File: rtl/pc_sequencer_next_sel.sv
// Next-PC selection: jump > branch_taken > pc+4, plus target alignment handling.
// With PC_TRAP_EN defined a misaligned flag is produced; otherwise target[1:0] is cleared.
module pc_next_sel
   import pc_sequencer_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_target,
`ifdef PC_TRAP_EN
   output logic            misaligned,
`endif
   output logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] pc_plus4
);

   logic            redirect;
   logic [XLEN-1:0] target;

   assign pc_plus4 = pc + XLEN'(PC_INCR);
   assign redirect = jump | branch_taken;
   assign target   = jump ? jump_target : branch_target;

`ifdef PC_TRAP_EN
   // The sequential path is always aligned because pc itself always is.
   assign misaligned = redirect && (target[1:0] != 2'b00);
   assign next_pc    = redirect ? target : pc_plus4;
`else
   assign next_pc    = redirect ? (target & ~XLEN'(3)) : pc_plus4;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch/execute sequencer for the core.
// Optional macro PC_TRAP_EN: misaligned redirects trap to TRAP_VECTOR and record epc.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
`ifdef PC_TRAP_EN
   ,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
`endif
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   output logic            instr_valid,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_target,
   input  logic            halt,
`ifdef PC_TRAP_EN
   output logic            trap_taken,
   output logic [XLEN-1:0] epc,
`endif
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            halted
);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, next_pc;
   logic            pc_load;
`ifdef PC_TRAP_EN
   logic            misaligned;
   logic            trap_set;
`endif

   pc_next_sel #(.XLEN(XLEN)) u_next_sel (
      .pc            (pc_q),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
`ifdef PC_TRAP_EN
      .misaligned    (misaligned),
`endif
      .next_pc       (next_pc),
      .pc_plus4      (pc_plus4)
   );

   // NOTE: sequential state uses <= so every register samples pre-edge values together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RST_HOLD;
         pc_q    <= RESET_VECTOR;
      end else begin
         state_q <= state_d;
         if (pc_load) pc_q <= pc_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      pc_d        = next_pc;
      pc_load     = 1'b0;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      halted      = 1'b0;
`ifdef PC_TRAP_EN
      trap_set    = 1'b0;
`endif
      case (state_q)
         ST_RST_HOLD: state_d = ST_FETCH;
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            instr_valid = 1'b1;
            // Stall outranks halt, and halt outranks any redirect.
            if (!stall) begin
               if (halt) begin
                  state_d = ST_HALTED;
               end else begin
                  state_d = ST_FETCH;
                  pc_load = 1'b1;
`ifdef PC_TRAP_EN
                  if (misaligned) begin
                     pc_d     = TRAP_VECTOR;
                     trap_set = 1'b1;
                  end
`endif
               end
            end
         end
         ST_HALTED: halted = 1'b1;
         default:   state_d = ST_RST_HOLD;
      endcase
   end

`ifdef PC_TRAP_EN
   // trap_taken is registered so it lands on the first FETCH cycle after the redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_taken <= 1'b0;
         epc        <= '0;
      end else begin
         trap_taken <= trap_set;
         if (trap_set) epc <= pc_q;
      end
   end
`endif

   assign pc        = pc_q;
   assign imem_addr = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; covers the PC_TRAP_EN build when defined.
module tb_pc_sequencer;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic            instr_valid;
   logic            stall;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            jump;
   logic [XLEN-1:0] jump_target;
   logic            halt;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic            halted;
`ifdef PC_TRAP_EN
   logic            trap_taken;
   logic [XLEN-1:0] epc;
`endif

   int errors = 0;
   int checks = 0;

   pc_sequencer #(.XLEN(XLEN)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .instr_valid   (instr_valid),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .halt          (halt),
`ifdef PC_TRAP_EN
      .trap_taken    (trap_taken),
      .epc           (epc),
`endif
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Holds reset for two cycles and releases it on a falling edge; DUT is then in RST_HOLD.
   task automatic do_reset(input logic ready);
      rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; halt = 1'b0;
      branch_target = '0; jump_target = '0; imem_ready = ready;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // From reset, jumps to target and returns at the falling edge inside EXEC at target.
   task automatic reach_exec_at(input logic [XLEN-1:0] target);
      do_reset(1'b1);
      @(negedge clk);                       // FETCH pc=0
      @(negedge clk);                       // EXEC pc=0
      jump = 1'b1; jump_target = target;
      @(negedge clk);                       // FETCH pc=target
      jump = 1'b0;
      @(negedge clk);                       // EXEC pc=target
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      rst_n = 1'b0;
      #1;
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", pc); end
      checks++; if ({imem_req, instr_valid, halted} !== 3'b000) begin errors++;
         $display("FAIL reset_outs: req/valid/halted got %b want 000", {imem_req, instr_valid, halted}); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_after_hold: req got %b want 1", imem_req); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_abort_fetch: req got %b want 0", imem_req); end
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      logic [XLEN-1:0] exp_pc;
      logic            exp_valid;
      do_reset(1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         exp_pc    = 32'((i / 2) * 4);
         exp_valid = (i % 2) == 1;
         checks++; if (pc !== exp_pc || imem_addr !== exp_pc) begin errors++;
            $display("FAIL seq_pc[%0d]: pc %h addr %h want %h", i, pc, imem_addr, exp_pc); end
         checks++; if (instr_valid !== exp_valid || imem_req !== !exp_valid) begin errors++;
            $display("FAIL seq_hs[%0d]: valid %b req %b want valid %b", i, instr_valid, imem_req, exp_valid); end
      end
   endtask

   task automatic test_fetch_wait();
      do_reset(1'b0);
      @(negedge clk);                       // FETCH pc=0, ready low
      imem_ready = 1'b1;
      @(negedge clk);                       // EXEC pc=0
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++;
            $display("FAIL wait_hs[%0d]: req %b valid %b want 1 0", i, imem_req, instr_valid); end
         checks++; if (pc !== 32'h4 || imem_addr !== 32'h4) begin errors++;
            $display("FAIL wait_pc[%0d]: pc %h addr %h want 00000004", i, pc, imem_addr); end
      end
      imem_ready = 1'b1;
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || pc !== 32'h4) begin errors++;
         $display("FAIL wait_exec: valid %b pc %h want 1 00000004", instr_valid, pc); end
   endtask

   task automatic test_redirect();
      reach_exec_at(32'h10);
      branch_taken = 1'b1; branch_target = 32'h40; jump = 1'b1; jump_target = 32'h80;
      @(negedge clk);
      checks++; if (pc !== 32'h80) begin errors++; $display("FAIL jump_over_branch: pc %h want 00000080", pc); end
      branch_taken = 1'b0; jump = 1'b0;
      @(negedge clk);                       // EXEC at 0x80
      branch_taken = 1'b1; branch_target = 32'h40;
      @(negedge clk);
      branch_taken = 1'b0;
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL branch: pc %h want 00000040", pc); end
      checks++; if (pc_plus4 !== 32'h44) begin errors++; $display("FAIL pc_plus4: got %h want 00000044", pc_plus4); end
   endtask

   task automatic test_stall();
      reach_exec_at(32'h20);
      stall = 1'b1; halt = 1'b1; jump = 1'b1; jump_target = 32'h60;
      @(negedge clk);
      halt = 1'b0;
      checks++; if (pc !== 32'h20 || instr_valid !== 1'b1 || halted !== 1'b0) begin errors++;
         $display("FAIL stall1: pc %h valid %b halted %b want 00000020 1 0", pc, instr_valid, halted); end
      @(negedge clk);
      checks++; if (pc !== 32'h20 || instr_valid !== 1'b1) begin errors++;
         $display("FAIL stall2: pc %h valid %b want 00000020 1", pc, instr_valid); end
      stall = 1'b0;
      @(negedge clk);
      jump = 1'b0;
      checks++; if (pc !== 32'h60 || imem_req !== 1'b1) begin errors++;
         $display("FAIL stall_release: pc %h req %b want 00000060 1", pc, imem_req); end
   endtask

   task automatic test_wrap_halt();
      reach_exec_at(32'hFFFF_FFFC);
      checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h want 00000000", pc_plus4); end
      @(negedge clk);
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: pc %h want 00000000", pc); end
      @(negedge clk);                       // EXEC pc=0
      @(negedge clk);                       // FETCH pc=4
      @(negedge clk);                       // EXEC pc=4
      halt = 1'b1; jump = 1'b1; jump_target = 32'h80;
      @(negedge clk);
      halt = 1'b0; jump = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h4) begin errors++;
            $display("FAIL halted[%0d]: halted %b req %b valid %b pc %h want 1 0 0 00000004",
                     i, halted, imem_req, instr_valid, pc); end
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (pc !== 32'h0 || halted !== 1'b0) begin errors++;
         $display("FAIL halt_reset: pc %h halted %b want 00000000 0", pc, halted); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || pc !== 32'h0) begin errors++;
         $display("FAIL restart: req %b pc %h want 1 00000000", imem_req, pc); end
   endtask

   task automatic test_misaligned();
      reach_exec_at(32'h30);
      jump = 1'b1; jump_target = 32'h42;
      @(negedge clk);
      jump = 1'b0;
`ifdef PC_TRAP_EN
      checks++; if (pc !== 32'h100 || epc !== 32'h30 || trap_taken !== 1'b1) begin errors++;
         $display("FAIL trap: pc %h epc %h trap %b want 00000100 00000030 1", pc, epc, trap_taken); end
      @(negedge clk);
      checks++; if (trap_taken !== 1'b0 || epc !== 32'h30) begin errors++;
         $display("FAIL trap_pulse: trap %b epc %h want 0 00000030", trap_taken, epc); end
`else
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL align_jump: pc %h want 00000040", pc); end
      @(negedge clk);                       // EXEC at 0x40
      branch_taken = 1'b1; branch_target = 32'h47;
      @(negedge clk);
      branch_taken = 1'b0;
      checks++; if (pc !== 32'h44) begin errors++; $display("FAIL align_branch: pc %h want 00000044", pc); end
`endif
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_fetch_wait();
      test_redirect();
      test_stall();
      test_wrap_halt();
      test_misaligned();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
